// File: rtl/need_status_monitor.sv
// Per-need status engine: hysteretic need flags, most-urgent-need selection,
// alert pulse and an ALIVE/CRITICAL/DEAD life-state FSM with tick-based death timing.
module need_status_monitor #(
  parameter int                   NUM_NEEDS    = 6,
  parameter int                   LEVEL_W      = 4,
  parameter int                   SET_THRESH   = 12,
  parameter int                   CLEAR_THRESH = 8,
  parameter logic [NUM_NEEDS-1:0] CRIT_MASK    = NUM_NEEDS'(1),
  parameter int                   DEATH_TICKS  = 4,
  parameter int                   IDX_W        = (NUM_NEEDS > 1) ? $clog2(NUM_NEEDS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic [NUM_NEEDS*LEVEL_W-1:0] levels,
  input  logic                         revive,
  output logic [NUM_NEEDS-1:0]         need_flags,
  output logic                         urgent_valid,
  output logic [IDX_W-1:0]             urgent_idx,
  output logic                         alert,
  output logic                         critical,
  output logic                         dead
);

  localparam int                 CNT_W   = $clog2(DEATH_TICKS + 1);
  localparam logic [LEVEL_W-1:0] SET_L   = LEVEL_W'(SET_THRESH);
  localparam logic [LEVEL_W-1:0] CLEAR_L = LEVEL_W'(CLEAR_THRESH);
  localparam logic [CNT_W-1:0]   DEATH_C = CNT_W'(DEATH_TICKS);

  typedef enum logic [1:0] {
    ST_ALIVE    = 2'd0,
    ST_CRITICAL = 2'd1,
    ST_DEAD     = 2'd2
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_NEEDS-1:0] r_flags;
  logic                 r_valid;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_alert;

  state_t               w_next_state;
  logic [CNT_W-1:0]     w_next_cnt;
  logic                 w_sat;
  logic [NUM_NEEDS-1:0] w_eval_flags;
  logic                 w_eval_valid;
  logic [IDX_W-1:0]     w_eval_idx;
  logic [LEVEL_W-1:0]   w_best_level;
  logic [NUM_NEEDS-1:0] w_flags_next;
  logic                 w_valid_next;
  logic [IDX_W-1:0]     w_idx_next;
  logic                 w_alert_next;

  // Hysteresis, saturation and urgent selection over the live levels.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_sat        = 1'b0;
    w_eval_flags = r_flags;
    w_eval_valid = 1'b0;
    w_eval_idx   = '0;
    w_best_level = '0;
    for (int i = 0; i < NUM_NEEDS; i++) begin
      if (CRIT_MASK[i] && (levels[i*LEVEL_W +: LEVEL_W] == {LEVEL_W{1'b1}}))
        w_sat = 1'b1;
      if (levels[i*LEVEL_W +: LEVEL_W] >= SET_L)
        w_eval_flags[i] = 1'b1;
      else if (levels[i*LEVEL_W +: LEVEL_W] <= CLEAR_L)
        w_eval_flags[i] = 1'b0;
    end
    // Strict '>' keeps the lowest index on a tie.
    for (int i = 0; i < NUM_NEEDS; i++) begin
      if (w_eval_flags[i] &&
          (!w_eval_valid || (levels[i*LEVEL_W +: LEVEL_W] > w_best_level))) begin
        w_eval_valid = 1'b1;
        w_eval_idx   = IDX_W'(i);
        w_best_level = levels[i*LEVEL_W +: LEVEL_W];
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    unique case (r_state)
      ST_ALIVE: begin
        if (w_sat) begin
          w_next_state = ST_CRITICAL;
          w_next_cnt   = '0;
        end
      end
      ST_CRITICAL: begin
        if (!w_sat) begin
          w_next_state = ST_ALIVE;
          w_next_cnt   = '0;
        end else if (tick) begin
          if (r_cnt != DEATH_C)
            w_next_cnt = r_cnt + CNT_W'(1);
          if (w_next_cnt == DEATH_C)
            w_next_state = ST_DEAD;
        end
      end
      ST_DEAD: begin
        if (revive) begin
          w_next_state = ST_ALIVE;
          w_next_cnt   = '0;
        end
      end
      default: begin
        w_next_state = ST_ALIVE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Outputs follow the state being entered; a dead pet ignores its levels.
  always_comb begin
    w_flags_next = w_eval_flags;
    w_valid_next = w_eval_valid;
    w_idx_next   = w_eval_idx;
    w_alert_next = |(w_eval_flags & ~r_flags);
    if (r_state == ST_DEAD) begin
      w_valid_next = 1'b0;
      w_idx_next   = '0;
      w_alert_next = 1'b0;
      w_flags_next = revive ? '0 : '1;
    end else if (w_next_state == ST_DEAD) begin
      w_flags_next = '1;
      w_valid_next = 1'b0;
      w_idx_next   = '0;
      w_alert_next = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ALIVE;
      r_cnt   <= '0;
      r_flags <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_alert <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_flags <= w_flags_next;
      r_valid <= w_valid_next;
      r_idx   <= w_idx_next;
      r_alert <= w_alert_next;
    end
  end

  assign need_flags   = r_flags;
  assign urgent_valid = r_valid;
  assign urgent_idx   = r_idx;
  assign alert        = r_alert;
  assign critical     = (r_state == ST_CRITICAL);
  assign dead         = (r_state == ST_DEAD);

endmodule

// File: tb/tb_need_status_monitor.sv
// Directed bench: a vector table drives the default-parameter instance cycle by cycle,
// and a hand-written sequence exercises a small re-parameterised instance.
module tb_need_status_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        reset, tick, revive;
  logic [23:0] levels;
  logic [5:0]  need_flags;
  logic        urgent_valid, alert, critical, dead;
  logic [2:0]  urgent_idx;

  need_status_monitor dut (
    .clk(clk), .reset(reset), .tick(tick), .levels(levels), .revive(revive),
    .need_flags(need_flags), .urgent_valid(urgent_valid), .urgent_idx(urgent_idx),
    .alert(alert), .critical(critical), .dead(dead)
  );

  // Small instance: 3 channels, 6-bit levels, mask on ch1/ch2, dies on first tick
  logic        reset2, tick2, revive2;
  logic [17:0] levels2;
  logic [2:0]  need_flags2;
  logic        urgent_valid2, alert2, critical2, dead2;
  logic [1:0]  urgent_idx2;

  need_status_monitor #(
    .NUM_NEEDS(3), .LEVEL_W(6), .SET_THRESH(40), .CLEAR_THRESH(20),
    .CRIT_MASK(3'b110), .DEATH_TICKS(1)
  ) dut2 (
    .clk(clk), .reset(reset2), .tick(tick2), .levels(levels2), .revive(revive2),
    .need_flags(need_flags2), .urgent_valid(urgent_valid2), .urgent_idx(urgent_idx2),
    .alert(alert2), .critical(critical2), .dead(dead2)
  );

  typedef struct packed {
    logic        rst;
    logic        tck;
    logic        rev;
    logic [23:0] lv;
    logic [5:0]  flags;
    logic        valid;
    logic [2:0]  idx;
    logic        alrt;
    logic        crit;
    logic        dd;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic tck, input logic rev, input logic [23:0] lv,
                     input logic [5:0] flags, input logic valid, input logic [2:0] idx,
                     input logic alrt, input logic crit, input logic dd);
    vec_t v;
    v = '{rst, tck, rev, lv, flags, valid, idx, alrt, crit, dd};
    vq.push_back(v);
  endtask

  task automatic step2(input logic rst, input logic tck, input logic [17:0] lv);
    @(negedge clk);
    reset2 = rst; tick2 = tck; levels2 = lv; revive2 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check2(input string tag, input logic [2:0] flags, input logic valid,
                        input logic [1:0] idx, input logic alrt, input logic crit, input logic dd);
    check({tag, " flags"}, 32'(need_flags2), 32'(flags));
    check({tag, " valid"}, 32'(urgent_valid2), 32'(valid));
    check({tag, " idx"},   32'(urgent_idx2), 32'(idx));
    check({tag, " alert"}, 32'(alert2), 32'(alrt));
    check({tag, " crit"},  32'(critical2), 32'(crit));
    check({tag, " dead"},  32'(dead2), 32'(dd));
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; revive = 1'b0; levels = '0;
    reset2 = 1'b1; tick2 = 1'b0; revive2 = 1'b0; levels2 = '0;

    //   rst tck rev levels        flags  v idx a  c  d
    // reset, reset priority over levels
    add(1, 0, 0, 24'h000000, 6'h00, 0, 0, 0, 0, 0);
    add(1, 0, 0, 24'h00C000, 6'h00, 0, 0, 0, 0, 0);
    // hysteresis on ch3: 12 set, 10 hold, 8 clear, 12 set again
    add(0, 0, 0, 24'h00C000, 6'h08, 1, 3, 1, 0, 0);
    add(0, 0, 0, 24'h00A000, 6'h08, 1, 3, 0, 0, 0);
    add(0, 0, 0, 24'h008000, 6'h00, 0, 0, 0, 0, 0);
    add(0, 0, 0, 24'h00C000, 6'h08, 1, 3, 1, 0, 0);
    add(0, 0, 0, 24'h000000, 6'h00, 0, 0, 0, 0, 0);
    // urgency: ch1=13 ch4=14 -> 4; tie at 14 -> 1; all zero -> none
    add(0, 0, 0, 24'h0E00D0, 6'h12, 1, 4, 1, 0, 0);
    add(0, 0, 0, 24'h0E00E0, 6'h12, 1, 1, 0, 0, 0);
    add(0, 0, 0, 24'h000000, 6'h00, 0, 0, 0, 0, 0);
    // death: saturate ch0, four ticks (one idle cycle in between holds the count)
    add(0, 0, 0, 24'h00000F, 6'h01, 1, 0, 1, 1, 0);
    add(0, 1, 0, 24'h00000F, 6'h01, 1, 0, 0, 1, 0);
    add(0, 0, 0, 24'h00000F, 6'h01, 1, 0, 0, 1, 0);
    add(0, 1, 0, 24'h00000F, 6'h01, 1, 0, 0, 1, 0);
    add(0, 1, 0, 24'h00000F, 6'h01, 1, 0, 0, 1, 0);
    add(0, 1, 0, 24'h00000F, 6'h3F, 0, 0, 1, 0, 1);
    add(0, 1, 0, 24'h00000F, 6'h3F, 0, 0, 0, 0, 1);
    // dead ignores a non-mask channel; revive clears without alert
    add(0, 0, 0, 24'h000F0F, 6'h3F, 0, 0, 0, 0, 1);
    add(0, 0, 1, 24'h000F0F, 6'h00, 0, 0, 0, 0, 0);
    // recovery race: count to 3, drop ch0 with a tick -> ALIVE
    add(0, 0, 0, 24'h00000F, 6'h01, 1, 0, 1, 1, 0);
    add(0, 1, 0, 24'h00000F, 6'h01, 1, 0, 0, 1, 0);
    add(0, 1, 0, 24'h00000F, 6'h01, 1, 0, 0, 1, 0);
    add(0, 1, 0, 24'h00000F, 6'h01, 1, 0, 0, 1, 0);
    add(0, 1, 0, 24'h00000E, 6'h01, 1, 0, 0, 0, 0);
    // re-saturate (tick ignored on entry), then a full four ticks to die
    add(0, 1, 0, 24'h00000F, 6'h01, 1, 0, 0, 1, 0);
    add(0, 1, 0, 24'h00000F, 6'h01, 1, 0, 0, 1, 0);
    add(0, 1, 0, 24'h00000F, 6'h01, 1, 0, 0, 1, 0);
    add(0, 1, 0, 24'h00000F, 6'h01, 1, 0, 0, 1, 0);
    add(0, 1, 0, 24'h00000F, 6'h3F, 0, 0, 1, 0, 1);
    // revive with saturated levels present: levels not evaluated this cycle
    add(0, 0, 1, 24'h00000F, 6'h00, 0, 0, 0, 0, 0);
    // reset while in CRITICAL, then the counter must restart from zero
    add(0, 0, 0, 24'h00000F, 6'h01, 1, 0, 1, 1, 0);
    add(0, 1, 0, 24'h00000F, 6'h01, 1, 0, 0, 1, 0);
    add(1, 1, 0, 24'h00000F, 6'h00, 0, 0, 0, 0, 0);
    add(0, 0, 0, 24'h00000F, 6'h01, 1, 0, 1, 1, 0);
    add(0, 1, 0, 24'h00000F, 6'h01, 1, 0, 0, 1, 0);
    add(0, 1, 0, 24'h00000F, 6'h01, 1, 0, 0, 1, 0);
    add(0, 1, 0, 24'h00000F, 6'h01, 1, 0, 0, 1, 0);
    add(0, 1, 0, 24'h00000F, 6'h3F, 0, 0, 1, 0, 1);

    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst; tick = vq[i].tck; revive = vq[i].rev; levels = vq[i].lv;
      @(posedge clk);
      #1;
      check($sformatf("v%0d flags", i), 32'(need_flags),   32'(vq[i].flags));
      check($sformatf("v%0d valid", i), 32'(urgent_valid), 32'(vq[i].valid));
      check($sformatf("v%0d idx", i),   32'(urgent_idx),   32'(vq[i].idx));
      check($sformatf("v%0d alert", i), 32'(alert),        32'(vq[i].alrt));
      check($sformatf("v%0d crit", i),  32'(critical),     32'(vq[i].crit));
      check($sformatf("v%0d dead", i),  32'(dead),         32'(vq[i].dd));
    end

    // Small instance: ch0 saturation is outside the mask, ch1 saturation kills on one tick
    step2(1'b1, 1'b0, 18'h00000);
    check2("p reset", 3'b000, 0, 2'd0, 0, 0, 0);
    step2(1'b0, 1'b1, 18'h0003F);
    check2("p ch0 sat", 3'b001, 1, 2'd0, 1, 0, 0);
    step2(1'b0, 1'b1, 18'h0003F);
    check2("p ch0 hold", 3'b001, 1, 2'd0, 0, 0, 0);
    step2(1'b0, 1'b0, 18'h00FC0);
    check2("p ch1 sat", 3'b010, 1, 2'd1, 1, 1, 0);
    step2(1'b0, 1'b1, 18'h00FC0);
    check2("p ch1 tick", 3'b111, 0, 2'd0, 1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/need_status_monitor.md
Name: need_status_monitor

Overview:
Parametrised per-need status engine for the pet core. It takes NUM_NEEDS packed need levels (hunger, happiness, health, hygiene, energy, social by default) and produces registered outputs:
- hysteretic per-need flags;
- a most-urgent-need index;
- a one-cycle alert pulse;
- a life-state FSM (ALIVE/CRITICAL/DEAD) with tick-based death persistence.
It sits between the need counters and the display/sound controllers.

Parameters:
NUM_NEEDS, 6, number of need channels (>=1)
LEVEL_W, 4, width of each need level
SET_THRESH, 12, level >= this sets the channel flag
CLEAR_THRESH, 8, level <= this clears the channel flag (must be < SET_THRESH)
CRIT_MASK, 6'b000001, channels whose saturation (all-ones level) drives the death FSM; width NUM_NEEDS
DEATH_TICKS, 4, consecutive ticks in CRITICAL before DEAD (>=1)
IDX_W, max(1,clog2(NUM_NEEDS)), width of urgent_idx

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
tick  input  1  one-cycle time-base strobe
levels  input  NUM_NEEDS*LEVEL_W  packed levels, channel i at [i*LEVEL_W +: LEVEL_W]
revive  input  1  leave DEAD (ignored in other states)
need_flags  output  NUM_NEEDS  per-channel need flags
urgent_valid  output  1  at least one flag set and not DEAD
urgent_idx  output  IDX_W  index of most urgent flagged channel
alert  output  1  one-cycle pulse on new need or death
critical  output  1  FSM in CRITICAL
dead  output  1  FSM in DEAD

Behaviour:
- Clock and reset: all outputs registered on posedge clk. reset is synchronous, active-high, and has priority over everything. Reset values:
  - need_flags=0, urgent_valid=0, urgent_idx=0, alert=0, critical=0, dead=0;
  - FSM=ALIVE, death counter=0.
- Latency: a levels or tick change sampled at edge N is reflected in the outputs after edge N.
- Flags (ALIVE/CRITICAL): per channel, next flag = 1 if level>=SET_THRESH; 0 if level<=CLEAR_THRESH; otherwise hold. Comparisons are unsigned, LEVEL_W-bit.
- Urgent selection:
  - Uses the next-flag vector and current levels.
  - urgent_idx = flagged channel with the highest level; ties go to the lowest index.
  - urgent_valid = any next flag set.
  - If no flag is set: urgent_idx=0, urgent_valid=0.
- Saturation: sat = OR over CRIT_MASK channels of (level == all-ones).
- FSM transitions:
  - ALIVE: sat -> CRITICAL, counter=0.
  - CRITICAL with !sat -> ALIVE, counter=0. This has priority over a tick in the same cycle.
  - CRITICAL with sat and tick: counter+1. When counter+1 == DEATH_TICKS -> DEAD.
  - CRITICAL with sat and no tick: hold.
  - DEAD is sticky. revive=1 -> ALIVE: counter=0, need_flags=0, urgent_valid=0, urgent_idx=0. Levels are not evaluated in that cycle.
- Counter: width clog2(DEATH_TICKS+1); saturates and never wraps.
- DEAD outputs: need_flags all ones, urgent_valid=0, urgent_idx=0, dead=1, critical=0. Levels are ignored.
- Alert:
  - alert=1 for exactly one cycle when any need_flags bit rises 0->1 outside DEAD, or on the cycle DEAD is entered.
  - The forced all-ones flags on entering DEAD produce one alert total, not one per bit.
  - No alert on revive or on reset release.
- critical/dead: mutually exclusive, direct decodes of the registered state.
- Reset mid-operation: immediate return to reset values, regardless of state or counter.

Test Plan:
- Hysteresis: ch3 level 12 -> flag[3]=1, alert pulse; level 10 -> flag[3] stays 1, no alert; level 8 -> flag[3]=0; level 12 again -> flag[3]=1, second alert.
- Urgency and ties: ch1=13, ch4=14 -> urgent_idx=4; ch1=14 -> urgent_idx=1 (tie goes to lower index); all levels 0 -> urgent_valid=0, urgent_idx=0.
- Death: ch0=15, 4 ticks -> critical=1 after the first edge; dead=1 on the edge of the 4th tick; need_flags=6'b111111; single alert pulse.
- Recovery race: in CRITICAL with counter=3, drop ch0 to 14 in the same cycle as tick -> ALIVE, critical=0, dead=0. Re-saturate -> needs 4 more ticks to reach DEAD.
- Revive and reset: in DEAD, raise ch2=15 (non-mask) -> no change; revive -> need_flags=0, dead=0, no alert. reset asserted while in CRITICAL -> all outputs 0 next cycle.
- Parametrisation: NUM_NEEDS=3, LEVEL_W=6, SET=40, CLEAR=20, CRIT_MASK=3'b110, DEATH_TICKS=1 -> ch1=63 plus one tick -> DEAD; ch0=63 alone never leaves ALIVE.
